// File: rtl/transkid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : transkid_pkg
//  Description : Shared constants and helpers for the transparent skid FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package transkid_pkg;

    // Smallest depth that still registers both output and input ready.
    localparam int MIN_DEPTH = 2;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/transkid_if.sv
`default_nettype none
// ============================================================================
//  Module      : transkid_if
//  Description : One valid/ready stream channel (valid, data, ready).
//  Revision    : 1.0 - initial release
// ============================================================================
interface transkid_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    // Producer side drives valid/data and observes ready.
    modport master (output valid, output data, input ready);
    // Consumer side observes valid/data and drives ready.
    modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/transkid_ram.sv
`default_nettype none
// ============================================================================
//  Module      : transkid_ram
//  Description : ENTRIES x DATA_WIDTH register array, one synchronous write
//                port and one asynchronous read port (FIFO backing store).
//  Revision    : 1.0 - initial release
// ============================================================================
module transkid_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 3,
    parameter int AW         = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [ENTRIES];

    // Store a beat at the write pointer; contents need no reset since the
    // control logic only reads entries it has written.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/transkid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : transkid_fifo
//  Description : Transparent skid FIFO of DEPTH entries (output register plus
//                a DEPTH-1 circular buffer). out_valid, out_data and in_ready
//                are all registered; provides occupancy, almost-full and a
//                synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module transkid_fifo
    import transkid_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PASS_STALL = 0,
    parameter int AF_THRESH  = DEPTH - 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    transkid_if.slave                   in_ch,
    transkid_if.master                  out_ch,
    output logic [occ_width(DEPTH)-1:0] count,
    output logic                        almost_full
);

    localparam int              c_cw       = occ_width(DEPTH);
    localparam int              c_entries  = DEPTH - 1;
    localparam int              c_aw       = (c_entries > 1) ? $clog2(c_entries) : 1;
    localparam logic [c_aw-1:0] c_last_ptr = c_aw'(c_entries - 1);

    generate
        if (DEPTH < MIN_DEPTH || AF_THRESH > DEPTH) begin : g_param_check
            $error("transkid_fifo: DEPTH must be >= 2 and AF_THRESH <= DEPTH");
        end
    endgenerate

    logic [c_cw-1:0]       r_count;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_in_ready;
    logic                  r_almost_full;
    logic [c_aw-1:0]       r_rd_ptr;
    logic [c_aw-1:0]       r_wr_ptr;

    logic                  w_insert;
    logic                  w_remove;
    logic                  w_buf_empty;
    logic                  w_to_out;
    logic                  w_to_buf;
    logic                  w_pop;
    logic [c_cw-1:0]       w_count_next;
    logic [c_cw-1:0]       w_count_eff;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Buffer pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [c_aw-1:0] ptr_inc(input logic [c_aw-1:0] p);
        return (p == c_last_ptr) ? '0 : p + c_aw'(1);
    endfunction

    assign w_insert    = in_ch.valid & r_in_ready;
    assign w_remove    = r_out_valid & out_ch.ready;
    // The output register holds one beat whenever count is non-zero, so
    // the circular buffer is empty exactly when count <= 1.
    assign w_buf_empty = (r_count <= c_cw'(1));
    // A new beat bypasses the buffer only if it would become the head.
    assign w_to_out    = w_insert & w_buf_empty & (~r_out_valid | w_remove);
    assign w_to_buf    = w_insert & ~w_to_out;
    assign w_pop       = w_remove & ~w_buf_empty;

    // Next occupancy from the two handshakes; flush forces it to zero.
    always_comb begin
        w_count_next = r_count;
        if (w_insert && !w_remove) begin
            w_count_next = r_count + c_cw'(1);
        end else if (!w_insert && w_remove) begin
            w_count_next = r_count - c_cw'(1);
        end
        w_count_eff = flush ? '0 : w_count_next;
    end

    // Register all status outputs, the output stage and the buffer pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_in_ready    <= 1'b0;
            r_almost_full <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_count       <= w_count_eff;
            r_out_valid   <= (w_count_eff != '0);
            r_almost_full <= (w_count_eff >= c_cw'(AF_THRESH));
            r_in_ready    <= (w_count_eff < c_cw'(DEPTH)) &&
                             ((PASS_STALL == 0) || out_ch.ready);
            if (flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_to_out) begin
                    r_out_data <= in_ch.data;
                end else if (w_pop) begin
                    r_out_data <= w_rd_data;
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                if (w_to_buf) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
            end
        end
    end

    transkid_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (c_entries),
        .AW         (c_aw)
    ) u_ram (
        .clk   (clk),
        .we    (w_to_buf & ~flush),
        .waddr (r_wr_ptr),
        .wdata (in_ch.data),
        .raddr (r_rd_ptr),
        .rdata (w_rd_data)
    );

    assign in_ch.ready  = r_in_ready;
    assign out_ch.valid = r_out_valid;
    assign out_ch.data  = r_out_data;
    assign count        = r_count;
    assign almost_full  = r_almost_full;

endmodule
`default_nettype wire
